width_expander: RTL and testbench

- Serial-to-parallel counterpart of the element serializer. Collects up to NO narrow elements of W_DATA bits from a dti stream into one wide word and emits that word on a dti producer.
- Each input element carries an end-of-transfer flag. A group closes after NO elements or on the flag, whichever comes first.
- Sits in front of wide datapaths that consume packed arrays.

---
 rtl/width_expander.sv | 93 +++++++++
 tb/tb_width_expander.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/width_expander.sv
`default_nettype none
// ============================================================================
// Module   : width_expander
// Summary  : Packs up to NO narrow dti elements into one wide word. A group
//            closes after NO elements or on an element carrying eot.
// Revision : 1.0 - initial release
// ============================================================================
module width_expander #(
  parameter int W_DATA = 16,
  parameter int NO     = 4,
  localparam int CW    = $clog2(NO + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [W_DATA:0]          din_data,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [NO*W_DATA+CW:0]    dout_data
);

  localparam int                 c_cnt_w = $clog2(NO);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(NO - 1);

  logic [c_cnt_w-1:0]   r_cnt;
  logic [W_DATA-1:0]    r_acc [NO];
  logic                 r_out_valid;
  logic [CW-1:0]        r_out_nvalid;
  logic                 r_out_eot;

  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_eot;
  logic                 w_close;
  logic [W_DATA-1:0]    w_elem;
  logic [NO*W_DATA-1:0] w_array;

  assign w_elem    = din_data[W_DATA-1:0];
  assign w_eot     = din_data[W_DATA];
  assign din_ready = !r_out_valid || dout_ready;
  assign w_in_hs   = din_valid && din_ready;
  assign w_out_hs  = r_out_valid && dout_ready;
  assign w_close   = w_eot || (r_cnt == c_last);

  // The accumulator doubles as the output register: it is only rewritten
  // once the previous word has been (or is being) consumed.
  genvar gi;
  generate
    for (gi = 0; gi < NO; gi++) begin : g_pack
      assign w_array[gi*W_DATA +: W_DATA] = r_acc[gi];
    end
  endgenerate

  assign dout_valid = r_out_valid;
  assign dout_data  = {r_out_eot, r_out_nvalid, w_array};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_nvalid <= '0;
      r_out_eot    <= 1'b0;
      for (int i = 0; i < NO; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_hs) begin
        // First element of a group zero-pads the remaining slots.
        for (int i = 0; i < NO; i++) begin
          if (c_cnt_w'(i) == r_cnt) begin
            r_acc[i] <= w_elem;
          end else if (r_cnt == '0) begin
            r_acc[i] <= '0;
          end
        end
        if (w_close) begin
          r_out_valid  <= 1'b1;
          r_out_nvalid <= CW'(r_cnt) + CW'(1);
          r_out_eot    <= w_eot;
          r_cnt        <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_width_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_width_expander
// Summary  : Directed vector table, multi-cycle corner sequences and a
//            random-handshake scoreboard for width_expander (NO=4, W_DATA=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_width_expander;

  localparam int c_w      = 16;
  localparam int c_no     = 4;
  localparam int c_dw     = c_no * c_w + 3 + 1;
  localparam int c_n_rand = 10000;

  logic            clk;
  logic            rst;
  logic            din_valid;
  logic            din_ready;
  logic [c_w:0]    din_data;
  logic            dout_valid;
  logic            dout_ready;
  logic [c_dw-1:0] dout_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            v;
    logic            e;
    logic [c_w-1:0]  d;
    logic            rdy;
    logic            x_dv;
    logic            x_dr;
    logic [c_dw-1:0] x_data;
  } vec_t;

  vec_t          vecs [$];
  logic [c_w:0]  exp_q [$];
  int            eot_words = 0;

  width_expander #(.W_DATA(c_w), .NO(c_no)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [c_dw-1:0] word(input logic eot, input logic [2:0] n,
                                           input logic [c_w-1:0] e3, input logic [c_w-1:0] e2,
                                           input logic [c_w-1:0] e1, input logic [c_w-1:0] e0);
    return {eot, n, e3, e2, e1, e0};
  endfunction

  function automatic vec_t mk(input logic v, input logic e, input logic [c_w-1:0] d,
                              input logic rdy, input logic x_dv, input logic x_dr,
                              input logic [c_dw-1:0] x_data);
    vec_t r;
    r.v = v; r.e = e; r.d = d; r.rdy = rdy;
    r.x_dv = x_dv; r.x_dr = x_dr; r.x_data = x_data;
    return r;
  endfunction

  task automatic chk(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [c_w-1:0] d, input logic rdy);
    @(negedge clk);
    din_valid  = v;
    din_data   = {e, d};
    dout_ready = rdy;
    #1;
  endtask

  // Scoreboard: rebuild the element stream from the word and its nvalid.
  task automatic check_word();
    logic        ok;
    logic        w_eot;
    int          n;
    logic [c_w:0] el;
    ok    = 1'b1;
    w_eot = dout_data[c_dw-1];
    n     = int'(dout_data[c_dw-2 -: 3]);
    if (n < 1 || n > c_no) ok = 1'b0;
    if (!w_eot && n != c_no) ok = 1'b0;
    if (w_eot) eot_words++;
    for (int k = 0; k < c_no; k++) begin
      if (ok && k < n) begin
        if (exp_q.size() == 0) begin
          ok = 1'b0;
        end else begin
          el = exp_q.pop_front();
          if (el[c_w-1:0] !== dout_data[k*c_w +: c_w]) ok = 1'b0;
          if (el[c_w] !== ((k == n - 1) ? w_eot : 1'b0)) ok = 1'b0;
        end
      end else if (ok && dout_data[k*c_w +: c_w] !== '0) begin
        ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_word: got %h, nvalid %0d, queued elements %0d", dout_data, n, exp_q.size());
    end
  endtask

  initial begin
    int   sent;
    int   cyc;
    int   eot_sent;
    logic took;

    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_dout_valid", dout_valid, 1'b0);
    chk("reset_din_ready", din_ready, 1'b1);
    chk("reset_dout_data", dout_data, '0);

    // Full group, early eot with zero padding, then 12 back-to-back elements.
    vecs.push_back(mk(1, 0, 16'h0011, 1, 0, 1, '0));
    vecs.push_back(mk(1, 0, 16'h0022, 1, 0, 1, '0));
    vecs.push_back(mk(1, 0, 16'h0033, 1, 0, 1, '0));
    vecs.push_back(mk(1, 1, 16'h0044, 1, 0, 1, '0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, word(1, 4, 16'h0044, 16'h0033, 16'h0022, 16'h0011)));
    vecs.push_back(mk(1, 0, 16'h00AA, 1, 0, 1, '0));
    vecs.push_back(mk(1, 1, 16'h00BB, 1, 0, 1, '0));
    vecs.push_back(mk(1, 1, 16'h0055, 1, 1, 1, word(1, 2, 16'h0, 16'h0, 16'h00BB, 16'h00AA)));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, word(1, 1, 16'h0, 16'h0, 16'h0, 16'h0055)));
    for (int k = 1; k <= 12; k++) begin
      vecs.push_back(mk(1, (k == 12), 16'(k), 1, (k == 5 || k == 9), 1,
                        (k == 5) ? word(0, 4, 16'd4, 16'd3, 16'd2, 16'd1)
                                 : word(0, 4, 16'd8, 16'd7, 16'd6, 16'd5)));
    end
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, word(1, 4, 16'd12, 16'd11, 16'd10, 16'd9)));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 1, '0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].e, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_dout_valid", i), dout_valid, vecs[i].x_dv);
      chk($sformatf("vec%0d_din_ready", i), din_ready, vecs[i].x_dr);
      if (vecs[i].x_dv) chk($sformatf("vec%0d_dout_data", i), dout_data, vecs[i].x_data);
    end

    // Backpressure: word held for 5 cycles while an element waits.
    for (int k = 1; k <= 4; k++) drive(1, (k == 4), 16'(16'h0100 + k), 1);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 16'h0777, 0);
      chk("bp_din_ready", din_ready, 1'b0);
      chk("bp_dout_valid", dout_valid, 1'b1);
      chk("bp_dout_data", dout_data, word(1, 4, 16'h0104, 16'h0103, 16'h0102, 16'h0101));
    end
    drive(1, 0, 16'h0777, 1);
    chk("bp_release_din_ready", din_ready, 1'b1);
    chk("bp_release_dout_valid", dout_valid, 1'b1);
    drive(1, 1, 16'h0888, 1);
    chk("bp_after_dout_valid", dout_valid, 1'b0);
    drive(0, 0, 16'h0000, 1);
    chk("bp_next_word", dout_data, word(1, 2, 16'h0, 16'h0, 16'h0888, 16'h0777));
    chk("bp_next_valid", dout_valid, 1'b1);

    // Reset in the middle of a group discards the partial data.
    drive(1, 0, 16'hDEAD, 1);
    drive(1, 0, 16'hBEEF, 1);
    drive(0, 0, 16'h0000, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_dout_valid", dout_valid, 1'b0);
    chk("midrst_din_ready", din_ready, 1'b1);
    for (int k = 0; k < 4; k++) drive(1, 0, 16'(16'h0010 + k), 1);
    drive(0, 0, 16'h0000, 1);
    chk("midrst_word", dout_data, word(0, 4, 16'h0013, 16'h0012, 16'h0011, 16'h0010));
    chk("midrst_word_valid", dout_valid, 1'b1);
    drive(0, 0, 16'h0000, 1);
    chk("midrst_drained", dout_valid, 1'b0);

    // Random valid/ready; data held stable while valid waits for ready.
    sent     = 0;
    cyc      = 0;
    eot_sent = 0;
    took     = 1'b0;
    while ((sent < c_n_rand || exp_q.size() != 0 || din_valid) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (took) din_valid = 1'b0;
      if (!din_valid && sent < c_n_rand && $urandom_range(0, 3) != 0) begin
        din_valid          = 1'b1;
        din_data[c_w-1:0]  = 16'($urandom);
        din_data[c_w]      = (sent == c_n_rand - 1) || ($urandom_range(0, 6) == 0);
      end
      dout_ready = (sent >= c_n_rand) || ($urandom_range(0, 3) != 0);
      #1;
      took = din_valid && din_ready;
      if (dout_valid && dout_ready) check_word();
      if (took) begin
        exp_q.push_back(din_data);
        sent++;
        if (din_data[c_w]) eot_sent++;
      end
    end
    checks++;
    if (cyc >= 60000) begin
      errors++;
      $display("FAIL rand_timeout: got %0d elements sent, %0d pending, required all drained", sent, exp_q.size());
    end
    chk("rand_eot_count", c_dw'(eot_words), c_dw'(eot_sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
